// File: rtl/espacc_rtl_basic_dma.sv
// espacc_rtl_basic_dma: loosely-coupled accelerator with a basic DMA master.
// It loads a program into local instruction memory, then for each pass it reads
// 8 data words, doubles each one and writes the results back to the same host
// addresses. acc_done pulses for one cycle when every pass has finished.
module espacc_rtl_basic_dma #(
  parameter int DMA_BUS_WIDTH  = 64,
  parameter int HOST_MAX_INSTR = 16,
  parameter int HOST_MAX_DATA  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              conf_info_reg0,
  input  logic [31:0]              conf_info_reg1,
  input  logic                     conf_done,
  output logic                     acc_done,
  output logic [31:0]              debug,
  output logic                     dma_read_ctrl_valid,
  input  logic                     dma_read_ctrl_ready,
  output logic [31:0]              dma_read_ctrl_data_index,
  output logic [31:0]              dma_read_ctrl_data_length,
  output logic [2:0]               dma_read_ctrl_data_size,
  input  logic                     dma_read_chnl_valid,
  output logic                     dma_read_chnl_ready,
  input  logic [DMA_BUS_WIDTH-1:0] dma_read_chnl_data,
  output logic                     dma_write_ctrl_valid,
  input  logic                     dma_write_ctrl_ready,
  output logic [31:0]              dma_write_ctrl_data_index,
  output logic [31:0]              dma_write_ctrl_data_length,
  output logic [2:0]               dma_write_ctrl_data_size,
  output logic                     dma_write_chnl_valid,
  input  logic                     dma_write_chnl_ready,
  output logic [DMA_BUS_WIDTH-1:0] dma_write_chnl_data
);

  // Words carried by one DMA beat, passes over the data region, beats per pass.
  localparam int WPB        = DMA_BUS_WIDTH / 32;
  localparam int PASSES     = HOST_MAX_DATA / 8;
  localparam int DATA_BEATS = 8 / WPB;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_CONFIG       = 4'd1,
    S_PROG_RD_CTRL = 4'd2,
    S_PROG_RD_CHNL = 4'd3,
    S_DATA_RD_CTRL = 4'd4,
    S_DATA_RD_CHNL = 4'd5,
    S_COMPUTE      = 4'd6,
    S_WR_CTRL      = 4'd7,
    S_WR_CHNL      = 4'd8,
    S_DONE         = 4'd9
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_base;      // program base word index
  logic [31:0] r_count;     // instruction count, already clamped
  logic [7:0]  r_cnt;       // beat counter, reused as the compute word index
  logic [7:0]  r_pass;      // current data pass

  logic [31:0] r_imem [HOST_MAX_INSTR];
  logic [31:0] r_buf  [8];

  logic [31:0] w_clamped;
  logic [31:0] w_prog_len;
  logic [31:0] w_data_index;
  logic        w_prog_last;
  logic        w_data_last;
  logic        w_cmp_last;
  logic        w_pass_last;
  logic        w_prog_fire;
  logic        w_data_fire;
  logic [DMA_BUS_WIDTH-1:0] w_wr_data;

  assign w_clamped    = (conf_info_reg1 > 32'(HOST_MAX_INSTR)) ? 32'(HOST_MAX_INSTR)
                                                               : conf_info_reg1;
  // Program read length rounds up so an odd word count still fetches its tail.
  assign w_prog_len   = (r_count + 32'(WPB - 1)) / 32'(WPB);
  assign w_data_index = r_base + 32'(HOST_MAX_INSTR) + {21'd0, r_pass, 3'd0};
  assign w_prog_last  = ({24'd0, r_cnt} == (w_prog_len - 32'd1));
  assign w_data_last  = (r_cnt == 8'(DATA_BEATS - 1));
  assign w_cmp_last   = (r_cnt == 8'd7);
  assign w_pass_last  = (({24'd0, r_pass} + 32'd1) >= 32'(PASSES));
  assign w_prog_fire  = (r_state == S_PROG_RD_CHNL) && dma_read_chnl_valid;
  assign w_data_fire  = (r_state == S_DATA_RD_CHNL) && dma_read_chnl_valid;

  assign debug = {8'd0, r_pass, r_cnt, 4'd0, r_state};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and handshake outputs; ctrl fields read 0 while valid is low.
  always_comb begin
    w_state_next               = r_state;
    acc_done                   = 1'b0;
    dma_read_ctrl_valid        = 1'b0;
    dma_read_ctrl_data_index   = 32'd0;
    dma_read_ctrl_data_length  = 32'd0;
    dma_read_ctrl_data_size    = 3'd0;
    dma_read_chnl_ready        = 1'b0;
    dma_write_ctrl_valid       = 1'b0;
    dma_write_ctrl_data_index  = 32'd0;
    dma_write_ctrl_data_length = 32'd0;
    dma_write_ctrl_data_size   = 3'd0;
    dma_write_chnl_valid       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (conf_done) w_state_next = S_CONFIG;
      end
      S_CONFIG: begin
        w_state_next = (r_count == 32'd0) ? S_DATA_RD_CTRL : S_PROG_RD_CTRL;
      end
      S_PROG_RD_CTRL: begin
        dma_read_ctrl_valid       = 1'b1;
        dma_read_ctrl_data_index  = r_base;
        dma_read_ctrl_data_length = w_prog_len;
        dma_read_ctrl_data_size   = SIZE_WORD;
        if (dma_read_ctrl_ready) w_state_next = S_PROG_RD_CHNL;
      end
      S_PROG_RD_CHNL: begin
        dma_read_chnl_ready = 1'b1;
        if (dma_read_chnl_valid && w_prog_last) w_state_next = S_DATA_RD_CTRL;
      end
      S_DATA_RD_CTRL: begin
        dma_read_ctrl_valid       = 1'b1;
        dma_read_ctrl_data_index  = w_data_index;
        dma_read_ctrl_data_length = 32'(DATA_BEATS);
        dma_read_ctrl_data_size   = SIZE_WORD;
        if (dma_read_ctrl_ready) w_state_next = S_DATA_RD_CHNL;
      end
      S_DATA_RD_CHNL: begin
        dma_read_chnl_ready = 1'b1;
        if (dma_read_chnl_valid && w_data_last) w_state_next = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (w_cmp_last) w_state_next = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        dma_write_ctrl_valid       = 1'b1;
        dma_write_ctrl_data_index  = w_data_index;
        dma_write_ctrl_data_length = 32'(DATA_BEATS);
        dma_write_ctrl_data_size   = SIZE_WORD;
        if (dma_write_ctrl_ready) w_state_next = S_WR_CHNL;
      end
      S_WR_CHNL: begin
        dma_write_chnl_valid = 1'b1;
        if (dma_write_chnl_ready && w_data_last) begin
          w_state_next = w_pass_last ? S_DONE : S_DATA_RD_CTRL;
        end
      end
      S_DONE: begin
        acc_done     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Configuration latch, beat/compute counter and pass index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base  <= 32'd0;
      r_count <= 32'd0;
      r_cnt   <= 8'd0;
      r_pass  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (conf_done) begin
            r_base  <= conf_info_reg0;
            r_count <= w_clamped;
            r_cnt   <= 8'd0;
            r_pass  <= 8'd0;
          end
        end
        S_PROG_RD_CHNL: begin
          if (dma_read_chnl_valid) r_cnt <= w_prog_last ? 8'd0 : r_cnt + 8'd1;
        end
        S_DATA_RD_CHNL: begin
          if (dma_read_chnl_valid) r_cnt <= w_data_last ? 8'd0 : r_cnt + 8'd1;
        end
        S_COMPUTE: begin
          r_cnt <= w_cmp_last ? 8'd0 : r_cnt + 8'd1;
        end
        S_WR_CHNL: begin
          if (dma_write_chnl_ready) begin
            if (w_data_last) begin
              r_cnt  <= 8'd0;
              r_pass <= r_pass + 8'd1;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        S_DONE: begin
          r_pass <= 8'd0;
        end
        default: ;
      endcase
    end
  end

  // Each instruction word has a fixed beat and lane; words past the count stay untouched.
  genvar gi;
  generate
    for (gi = 0; gi < HOST_MAX_INSTR; gi++) begin : g_imem
      // Capture this instruction word when its beat arrives.
      always_ff @(posedge clk) begin
        if (w_prog_fire && (r_cnt == 8'(gi / WPB)) && (32'(gi) < r_count)) begin
          r_imem[gi] <= dma_read_chnl_data[32*(gi % WPB) +: 32];
        end
      end
    end

    for (gi = 0; gi < 8; gi++) begin : g_buf
      // Fill from the read stream, then double in place on this word's compute cycle.
      always_ff @(posedge clk) begin
        if (w_data_fire && (r_cnt == 8'(gi / WPB))) begin
          r_buf[gi] <= dma_read_chnl_data[32*(gi % WPB) +: 32];
        end else if ((r_state == S_COMPUTE) && (r_cnt == 8'(gi))) begin
          r_buf[gi] <= {r_buf[gi][30:0], 1'b0};
        end
      end
    end

    for (gi = 0; gi < WPB; gi++) begin : g_wr_lane
      logic [2:0] w_addr;
      assign w_addr = 3'(r_cnt * 8'(WPB) + 8'(gi));
      assign w_wr_data[32*gi +: 32] = r_buf[w_addr];
    end
  endgenerate

  // The beat only changes on a handshake, so a stalled beat stays stable.
  assign dma_write_chnl_data = (r_state == S_WR_CHNL) ? w_wr_data : '0;

endmodule

// File: tb/tb_espacc_rtl_basic_dma.sv
// Directed testbench for espacc_rtl_basic_dma (64-bit bus, 16 instr, 16 data words).
module tb_espacc_rtl_basic_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] conf_info_reg0, conf_info_reg1;
  logic        conf_done;
  logic        acc_done;
  logic [31:0] debug;
  logic        dma_read_ctrl_valid, dma_read_ctrl_ready;
  logic [31:0] dma_read_ctrl_data_index, dma_read_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size;
  logic        dma_read_chnl_valid, dma_read_chnl_ready;
  logic [63:0] dma_read_chnl_data;
  logic        dma_write_ctrl_valid, dma_write_ctrl_ready;
  logic [31:0] dma_write_ctrl_data_index, dma_write_ctrl_data_length;
  logic [2:0]  dma_write_ctrl_data_size;
  logic        dma_write_chnl_valid, dma_write_chnl_ready;
  logic [63:0] dma_write_chnl_data;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] prog [16];
  logic [31:0] din  [8];
  logic [31:0] dout [8];

  espacc_rtl_basic_dma #(
    .DMA_BUS_WIDTH(64), .HOST_MAX_INSTR(16), .HOST_MAX_DATA(16)
  ) dut (
    .clk(clk), .rst(rst),
    .conf_info_reg0(conf_info_reg0), .conf_info_reg1(conf_info_reg1),
    .conf_done(conf_done), .acc_done(acc_done), .debug(debug),
    .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
    .dma_read_ctrl_data_index(dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
    .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_ready(dma_read_chnl_ready),
    .dma_read_chnl_data(dma_read_chnl_data),
    .dma_write_ctrl_valid(dma_write_ctrl_valid), .dma_write_ctrl_ready(dma_write_ctrl_ready),
    .dma_write_ctrl_data_index(dma_write_ctrl_data_index),
    .dma_write_ctrl_data_length(dma_write_ctrl_data_length),
    .dma_write_ctrl_data_size(dma_write_ctrl_data_size),
    .dma_write_chnl_valid(dma_write_chnl_valid), .dma_write_chnl_ready(dma_write_chnl_ready),
    .dma_write_chnl_data(dma_write_chnl_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_rd_ctrl_valid"}, dma_read_ctrl_valid, 0);
    chk({tag, "_rd_ctrl_index"}, dma_read_ctrl_data_index, 0);
    chk({tag, "_rd_ctrl_len"}, dma_read_ctrl_data_length, 0);
    chk({tag, "_rd_ctrl_size"}, dma_read_ctrl_data_size, 0);
    chk({tag, "_rd_chnl_ready"}, dma_read_chnl_ready, 0);
    chk({tag, "_wr_ctrl_valid"}, dma_write_ctrl_valid, 0);
    chk({tag, "_wr_ctrl_index"}, dma_write_ctrl_data_index, 0);
    chk({tag, "_wr_chnl_valid"}, dma_write_chnl_valid, 0);
    chk({tag, "_acc_done"}, acc_done, 0);
    chk({tag, "_debug"}, debug, 0);
  endtask

  task automatic configure(input logic [31:0] r0, input logic [31:0] r1);
    conf_info_reg0 = r0;
    conf_info_reg1 = r1;
    conf_done = 1'b1;
    step();
    conf_done = 1'b0;
    chk("config_state", debug[3:0], 1);
    step();
  endtask

  // Read one data pass from din; ends with the DUT in COMPUTE.
  task automatic read_pass(input logic [31:0] idx, input logic [7:0] pass);
    chk("drd_state", debug[3:0], 4);
    chk("drd_valid", dma_read_ctrl_valid, 1);
    chk("drd_index", dma_read_ctrl_data_index, idx);
    chk("drd_len", dma_read_ctrl_data_length, 4);
    chk("drd_size", dma_read_ctrl_data_size, 3'b010);
    chk("drd_pass", debug[23:16], pass);
    dma_read_ctrl_ready = 1'b1;
    step();
    dma_read_ctrl_ready = 1'b0;
    chk("dch_state", debug[3:0], 5);
    chk("dch_ready", dma_read_chnl_ready, 1);
    for (int b = 0; b < 4; b++) begin
      dma_read_chnl_valid = 1'b1;
      dma_read_chnl_data  = {din[2*b+1], din[2*b]};
      step();
      if (b == 1) begin
        dma_read_chnl_valid = 1'b0;
        dma_read_chnl_data  = 64'hDEAD_DEAD_DEAD_DEAD;
        step();
        chk("dch_gap_state", debug[3:0], 5);
        chk("dch_gap_cnt", debug[15:8], 2);
      end
    end
    dma_read_chnl_valid = 1'b0;
    dma_read_chnl_data  = 64'd0;
    chk("cmp_state", debug[3:0], 6);
    chk("cmp_rd_ready", dma_read_chnl_ready, 0);
  endtask

  // Compute cycles then write the pass back, checking against dout.
  task automatic write_pass(input logic [31:0] idx, input bit stall, input bit last);
    logic [63:0] expb;
    repeat (7) step();
    chk("cmp_hold_state", debug[3:0], 6);
    chk("cmp_hold_cnt", debug[15:8], 7);
    step();
    chk("wrc_state", debug[3:0], 7);
    chk("wrc_valid", dma_write_ctrl_valid, 1);
    chk("wrc_index", dma_write_ctrl_data_index, idx);
    chk("wrc_len", dma_write_ctrl_data_length, 4);
    chk("wrc_size", dma_write_ctrl_data_size, 3'b010);
    dma_write_ctrl_ready = 1'b1;
    step();
    dma_write_ctrl_ready = 1'b0;
    chk("wch_state", debug[3:0], 8);
    for (int b = 0; b < 4; b++) begin
      expb = {dout[2*b+1], dout[2*b]};
      chk("wch_valid", dma_write_chnl_valid, 1);
      chk("wch_data", dma_write_chnl_data, expb);
      if (stall && (b % 2 == 0)) begin
        step();
        chk("wch_stall_valid", dma_write_chnl_valid, 1);
        chk("wch_stall_data", dma_write_chnl_data, expb);
        chk("wch_stall_cnt", debug[15:8], b);
      end
      dma_write_chnl_ready = 1'b1;
      step();
      dma_write_chnl_ready = 1'b0;
    end
    if (last) begin
      chk("done_pulse", acc_done, 1);
      chk("done_state", debug[3:0], 9);
      chk("done_wch_valid", dma_write_chnl_valid, 0);
      step();
      check_quiet("post_done");
    end else begin
      chk("next_pass_state", debug[3:0], 4);
    end
  endtask

  initial begin
    rst = 1'b1;
    conf_info_reg0 = 0; conf_info_reg1 = 0; conf_done = 0;
    dma_read_ctrl_ready = 0; dma_read_chnl_valid = 0; dma_read_chnl_data = 0;
    dma_write_ctrl_ready = 0; dma_write_chnl_ready = 0;
    for (int i = 0; i < 16; i++) prog[i] = 32'hC0DE_0000 + 32'(i);
    repeat (3) step();
    rst = 1'b0;
    step();
    check_quiet("reset");

    // Full run: 16-instruction program, two passes.
    configure(32'd0, 32'd16);
    chk("prd_state", debug[3:0], 2);
    chk("prd_valid", dma_read_ctrl_valid, 1);
    chk("prd_index", dma_read_ctrl_data_index, 0);
    chk("prd_len", dma_read_ctrl_data_length, 8);
    chk("prd_size", dma_read_ctrl_data_size, 3'b010);
    step();
    chk("prd_wait_valid", dma_read_ctrl_valid, 1);
    dma_read_ctrl_ready = 1'b1;
    step();
    dma_read_ctrl_ready = 1'b0;
    chk("pch_state", debug[3:0], 3);
    chk("pch_ready", dma_read_chnl_ready, 1);
    for (int i = 0; i < 8; i++) begin
      dma_read_chnl_valid = 1'b1;
      dma_read_chnl_data  = {prog[2*i+1], prog[2*i]};
      step();
    end
    dma_read_chnl_valid = 1'b0;
    for (int i = 0; i < 16; i++) chk("imem", dut.r_imem[i], prog[i]);

    for (int k = 0; k < 8; k++) begin
      din[k]  = 32'(k + 1);
      dout[k] = 32'(2 * (k + 1));
    end
    read_pass(32'd16, 8'd0);
    write_pass(32'd16, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      din[k]  = 32'(k + 9);
      dout[k] = 32'(2 * (k + 9));
    end
    read_pass(32'd24, 8'd1);
    write_pass(32'd24, 1'b0, 1'b1);

    // Zero instructions skip the program read; carry bits are dropped; reset aborts.
    configure(32'h40, 32'd0);
    chk("skip_state", debug[3:0], 4);
    conf_info_reg0 = 32'hFFFF;
    conf_done = 1'b1;
    step();
    conf_done = 1'b0;
    chk("ignore_conf_state", debug[3:0], 4);
    chk("ignore_conf_index", dma_read_ctrl_data_index, 32'h50);
    din[0] = 32'h8000_0001; dout[0] = 32'h0000_0002;
    din[1] = 32'hFFFF_FFFF; dout[1] = 32'hFFFF_FFFE;
    din[2] = 32'h7FFF_FFFF; dout[2] = 32'hFFFF_FFFE;
    din[3] = 32'h0000_0000; dout[3] = 32'h0000_0000;
    din[4] = 32'h1234_5678; dout[4] = 32'h2468_ACF0;
    din[5] = 32'h4000_0000; dout[5] = 32'h8000_0000;
    din[6] = 32'hC000_0000; dout[6] = 32'h8000_0000;
    din[7] = 32'hDEAD_BEEF; dout[7] = 32'hBD5B_7DDE;
    read_pass(32'h50, 8'd0);
    write_pass(32'h50, 1'b1, 1'b0);
    read_pass(32'h58, 8'd1);
    repeat (3) step();
    chk("abort_pre_state", debug[3:0], 6);
    rst = 1'b1;
    step();
    check_quiet("abort");
    rst = 1'b0;
    step();
    check_quiet("abort_release");

    // Odd count: length rounds up and the unused high lane is not stored.
    configure(32'h200, 32'd3);
    chk("odd_len", dma_read_ctrl_data_length, 2);
    chk("odd_index", dma_read_ctrl_data_index, 32'h200);
    dma_read_ctrl_ready = 1'b1;
    step();
    dma_read_ctrl_ready = 1'b0;
    dma_read_chnl_valid = 1'b1;
    dma_read_chnl_data  = {32'h1111_0001, 32'h1111_0000};
    step();
    dma_read_chnl_data  = {32'h1111_0003, 32'h1111_0002};
    step();
    dma_read_chnl_valid = 1'b0;
    chk("odd_next_state", debug[3:0], 4);
    chk("odd_data_index", dma_read_ctrl_data_index, 32'h210);
    chk("odd_imem0", dut.r_imem[0], 32'h1111_0000);
    chk("odd_imem2", dut.r_imem[2], 32'h1111_0002);
    chk("odd_imem3", dut.r_imem[3], prog[3]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Over-long count clamps to 16 words; stray chnl valid before ctrl is ignored.
    configure(32'h0, 32'd100);
    chk("clamp_len", dma_read_ctrl_data_length, 8);
    dma_read_chnl_valid = 1'b1;
    step();
    dma_read_chnl_valid = 1'b0;
    chk("stray_state", debug[3:0], 2);
    chk("stray_ready", dma_read_chnl_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_quiet("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
